// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async FIFO read path (fifo_mem, fifo_rd_drain).
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Read-side bus of fifo_rd_drain: fifo_mem request/data plus downstream valid/ready stream.
interface fifo_rd_drain_if #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  r_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        input  empty, data_out, m_ready,
        output r_en, m_valid, m_data
    );

    modport slave (
        output empty, data_out, m_ready,
        input  r_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_drain_skid.sv
// rd_skid_buf: 2-entry FIFO-ordered skid buffer; head_o is always the oldest held word.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output occ_t                  occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    occ_t                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= S_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            occ_q   <= occ_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (occ_q)
            S_EMPTY: begin
                if (push_i) begin
                    slot0_d = push_data_i;
                    occ_d   = S_ONE;
                end
            end
            S_ONE: begin
                unique case ({push_i, pop_i})
                    2'b10: begin
                        slot1_d = push_data_i;
                        occ_d   = S_TWO;
                    end
                    2'b01:   occ_d   = S_EMPTY;
                    2'b11:   slot0_d = push_data_i;
                    default: ;
                endcase
            end
            S_TWO: begin
                // Simultaneous push/pop is unreachable but kept ordered for robustness.
                if (pop_i) begin
                    slot0_d = slot1_q;
                    if (push_i) slot1_d = push_data_i;
                    else        occ_d   = S_ONE;
                end
            end
            default: occ_d = S_EMPTY;
        endcase
    end

    assign occ_o  = occ_q;
    assign head_o = slot0_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && occ_q == S_TWO));

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain drain engine: issues r_en, absorbs fifo_mem read latency, streams words out.
// Optional delivered-word counter rd_count when FIFO_RD_STATS_EN is defined.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    fifo_rd_drain_if.master      bus
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] rd_count
`endif
);

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("fifo_rd_drain: DATA_WIDTH and CNT_WIDTH must be >= 1");
    end

    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  inflight_q;
    logic [2:0]            level;
    logic [2:0]            limit;

    assign pop = bus.m_valid & bus.m_ready;

    // occ + inflight - pop < 2, rearranged to avoid unsigned underflow.
    assign level = {1'b0, occ} + {2'b00, inflight_q};
    assign limit = 3'd2 + {2'b00, pop};

    always_comb begin
        bus.r_en = 1'b0;
        if (!rrst && !bus.empty && (level < limit)) bus.r_en = 1'b1;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) inflight_q <= 1'b0;
        else      inflight_q <= bus.r_en;
    end

    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (rclk),
        .rst         (rrst),
        .push_i      (inflight_q),
        .push_data_i (bus.data_out),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    assign bus.m_valid = (occ != S_EMPTY);
    assign bus.m_data  = head;

`ifdef FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pop) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: emulated FIFO, queue-based timing model, directed rows.
// Build with or without FIFO_RD_STATS_EN; rd_count checks follow the macro.
module tb_fifo_rd_drain;

    logic rclk;
    logic rrst;
    fifo_rd_drain_if #(.DATA_WIDTH(8)) bus ();
`ifdef FIFO_RD_STATS_EN
    logic [3:0] rd_count;
`endif

    fifo_rd_drain #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (4)
    ) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count (rd_count)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic [7:0] w;
        int         rdy;
    } ent_t;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        int         n;
        int         stall;
        int         exp_pulses;
    } row_t;

    ent_t       mq[$];
    logic [7:0] fq[$];
    logic [7:0] got[$];
    int         got_cyc[$];
    bit         launch_pend;
    logic [7:0] launch_word;
    bit         ready_drv;
    bit         chk_zero;
    int         cyc;
    int         rpulses;
    int         model_cnt;
    int         total;
    int         bad;
    row_t       rows[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A word launched in cycle c becomes visible to the consumer in cycle c+2.
    task automatic tick();
        bit ev, epop, er;
        @(negedge rclk);
        if (launch_pend) bus.data_out = launch_word;
        launch_pend  = 1'b0;
        bus.empty    = (fq.size() == 0);
        bus.m_ready  = ready_drv;
        #1;
        ev   = (mq.size() > 0) && (mq[0].rdy <= cyc);
        epop = ev && ready_drv;
        er   = !bus.empty && ((mq.size() - (epop ? 1 : 0)) < 2);
        check("r_en", bus.r_en, er);
        check("m_valid", bus.m_valid, ev);
        if (ev) check("m_data", bus.m_data, mq[0].w);
        if (chk_zero) check("m_data_idle", bus.m_data, 0);
`ifdef FIFO_RD_STATS_EN
        check("rd_count", rd_count, model_cnt % 16);
`endif
        if (epop) begin
            got.push_back(mq[0].w);
            got_cyc.push_back(cyc);
            void'(mq.pop_front());
            model_cnt++;
        end
        if (bus.r_en && fq.size() > 0) begin
            launch_word = fq.pop_front();
            launch_pend = 1'b1;
            mq.push_back('{launch_word, cyc + 2});
            rpulses++;
        end
        @(posedge rclk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst = 1'b1;
        #1;
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_r_en", bus.r_en, 0);
        fq.delete();
        mq.delete();
        launch_pend = 1'b0;
        model_cnt   = 0;
        bus.empty   = 1'b1;
        repeat (2) @(negedge rclk);
`ifdef FIFO_RD_STATS_EN
        check("rst_rd_count", rd_count, 0);
`endif
        rrst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        int         start;

        rows[0] = '{8'h11, 8'h11, 3, 0, 0};
        rows[1] = '{8'hA0, 8'h01, 8, 8, 2};
        rows[2] = '{8'h40, 8'h03, 5, 3, 2};
        rows[3] = '{8'h5C, 8'h00, 1, 4, 1};

        total = 0; bad = 0; cyc = 0; rpulses = 0; model_cnt = 0;
        launch_pend = 1'b0; launch_word = '0; chk_zero = 1'b0; ready_drv = 1'b0;
        rrst = 1'b1;
        bus.empty = 1'b1; bus.m_ready = 1'b0; bus.data_out = 8'h00;

        // Reset state, then idle with an empty FIFO.
        repeat (2) @(negedge rclk);
        #1;
        check("rst_r_en", bus.r_en, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        @(negedge rclk);
        rrst = 1'b0;
        chk_zero = 1'b1;
        repeat (10) tick();
        chk_zero = 1'b0;

        // Directed rows: streaming, backpressure, empty rising after a single issue.
        for (int r = 0; r < 4; r++) begin
            ready_drv = 1'b1;
            for (int k = 0; k < 40 && (mq.size() > 0 || fq.size() > 0 || launch_pend); k++) tick();
            got.delete();
            got_cyc.delete();
            rpulses = 0;
            ready_drv = (rows[r].stall == 0);
            for (int i = 0; i < rows[r].n; i++) begin
                w = rows[r].base + 8'(i) * rows[r].step;
                fq.push_back(w);
            end
            start = cyc;
            for (int k = 0; k < rows[r].stall; k++) tick();
            if (rows[r].stall > 0) begin
                check("stall_r_en_pulses", rpulses, rows[r].exp_pulses);
                #1;
                check("stall_m_valid", bus.m_valid, 1);
                check("stall_m_data", bus.m_data, rows[r].base);
            end
            ready_drv = 1'b1;
            for (int k = 0; k < 60 && got.size() < rows[r].n; k++) tick();
            check("row_delivered", got.size(), rows[r].n);
            for (int i = 0; i < got.size(); i++) begin
                w = rows[r].base + 8'(i) * rows[r].step;
                check("row_order", got[i], w);
            end
            if (rows[r].stall == 0 && got_cyc.size() == rows[r].n) begin
                check("first_valid_cyc", got_cyc[0], start + 2);
                check("last_valid_cyc", got_cyc[rows[r].n - 1], start + rows[r].n + 1);
            end
            repeat (3) tick();
            check("row_no_extra", got.size(), rows[r].n);
        end

        // Reset while two words are held: everything discarded.
        got.delete();
        ready_drv = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(8'hC0 + 8'(i));
        repeat (5) tick();
        #1;
        check("pre_rst_m_data", bus.m_data, 8'hC0);
        got.delete();
        do_reset();
        ready_drv = 1'b1;
        repeat (6) tick();
        check("post_rst_deliv", got.size(), 0);

        // Randomised traffic against the queue model.
        got.delete();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 6) fq.push_back(8'($urandom));
            ready_drv = ($urandom_range(0, 3) != 0);
            tick();
        end
        ready_drv = 1'b1;
        for (int k = 0; k < 40 && (mq.size() > 0 || fq.size() > 0 || launch_pend); k++) tick();
        check("rand_drained", mq.size() + fq.size(), 0);

        // Counter wrap: 18 words through a 4-bit counter.
        do_reset();
        got.delete();
        for (int i = 0; i < 18; i++) fq.push_back(8'h70 + 8'(i));
        ready_drv = 1'b1;
        for (int k = 0; k < 60 && got.size() < 18; k++) tick();
        check("stats_delivered", got.size(), 18);
        #1;
`ifdef FIFO_RD_STATS_EN
        check("rd_count_wrap", rd_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
